// File: rtl/recog_frame_sequencer.sv
// Frame-level sequencer for the projection / digit-recognition pipeline.
// Define RECOG_STABLE_FILTER_EN to publish only results that repeat over STABLE_CNT passes.
module recog_frame_sequencer #(
  parameter int NUM_ROW        = 1,
  parameter int NUM_COL        = 4,
  parameter int NUM_WIDTH      = (NUM_ROW*NUM_COL<<2)-1,
  parameter int TIMEOUT_FRAMES = 4,
  parameter int STABLE_CNT     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               vsync,
  input  logic               proj_done,
  input  logic [3:0]         num_row,
  input  logic [3:0]         num_col,
  input  logic [NUM_WIDTH:0] digit,
  output logic               proj_start,
  output logic [1:0]         frame_cnt,
  output logic               project_done_flag,
  output logic [NUM_WIDTH:0] result,
  output logic [7:0]         result_num,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               err_empty,
  output logic               err_timeout,
  output logic               err_overrun,
  input  logic               err_clr
);

  if (TIMEOUT_FRAMES < 1 || TIMEOUT_FRAMES > 15) begin : g_bad_timeout
    $error("TIMEOUT_FRAMES must be in 1..15");
  end
  if (STABLE_CNT < 2 || STABLE_CNT > 15) begin : g_bad_stable
    $error("STABLE_CNT must be in 2..15");
  end

  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROJ = 2'd1,
    BORD = 2'd2,
    FEAT = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        vsync_q;
  logic        vs_rise;
  logic        pd_seen;
  logic        pd_now;
  logic        pd_eff;
  logic [3:0]  row_l;
  logic [3:0]  col_l;
  logic [3:0]  row_eff;
  logic [3:0]  col_eff;
  logic        pass_ok;
  logic [3:0]  tmo_cnt;
  logic [7:0]  cap_num;

  logic        start_pass;
  logic        enter_bord;
  logic        enter_feat;
  logic        capture;
  logic        go_idle;
  logic        set_empty;
  logic        set_timeout;
  logic        tmo_inc;
  logic        publish;
  logic        set_overrun;

  assign vs_rise = vsync & ~vsync_q;

  // A proj_done landing on the closing vsync edge still belongs to the ending frame.
  assign pd_now  = (state == PROJ) && proj_done;
  assign pd_eff  = pd_seen || pd_now;
  assign row_eff = pd_now ? num_row : row_l;
  assign col_eff = pd_now ? num_col : col_l;
  assign pass_ok = pd_eff && (row_eff != 4'd0) && (col_eff != 4'd0);
  assign cap_num = {4'd0, row_l} * {4'd0, col_l};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (vs_rise) begin
      if (!enable) begin
        state_next = IDLE;
      end else begin
        case (state)
          IDLE:    state_next = PROJ;
          PROJ:    if (pass_ok) state_next = BORD;
          BORD:    state_next = FEAT;
          FEAT:    state_next = PROJ;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    start_pass  = 1'b0;
    enter_bord  = 1'b0;
    enter_feat  = 1'b0;
    capture     = 1'b0;
    go_idle     = 1'b0;
    set_empty   = 1'b0;
    set_timeout = 1'b0;
    tmo_inc     = 1'b0;
    if (vs_rise) begin
      if (!enable) begin
        go_idle = 1'b1;
      end else begin
        case (state)
          IDLE: start_pass = 1'b1;
          PROJ: begin
            if (pass_ok) begin
              enter_bord = 1'b1;
            end else if (pd_eff) begin
              set_empty  = 1'b1;
              start_pass = 1'b1;
            end else if (tmo_cnt == TMO_LAST) begin
              set_timeout = 1'b1;
              start_pass  = 1'b1;
            end else begin
              tmo_inc = 1'b1;
            end
          end
          BORD: enter_feat = 1'b1;
          FEAT: begin
            capture    = 1'b1;
            start_pass = 1'b1;
          end
          default: go_idle = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q           <= 1'b0;
      proj_start        <= 1'b0;
      frame_cnt         <= 2'd0;
      project_done_flag <= 1'b0;
      tmo_cnt           <= 4'd0;
      pd_seen           <= 1'b0;
      row_l             <= 4'd0;
      col_l             <= 4'd0;
    end else begin
      vsync_q    <= vsync;
      proj_start <= start_pass;
      if (pd_now) begin
        row_l <= num_row;
        col_l <= num_col;
      end
      if (go_idle || start_pass) begin
        frame_cnt         <= 2'd0;
        project_done_flag <= 1'b0;
        tmo_cnt           <= 4'd0;
      end else if (enter_bord) begin
        frame_cnt         <= 2'd1;
        project_done_flag <= 1'b1;
      end else if (enter_feat) begin
        frame_cnt <= 2'd2;
      end else if (tmo_inc) begin
        tmo_cnt <= tmo_cnt + 4'd1;
      end
      if (go_idle || start_pass || enter_bord) begin
        pd_seen <= 1'b0;
      end else if (pd_now) begin
        pd_seen <= 1'b1;
      end
    end
  end

`ifdef RECOG_STABLE_FILTER_EN
  localparam logic [3:0] STABLE_LIM = 4'(STABLE_CNT);

  logic [NUM_WIDTH:0] prev_digit;
  logic [7:0]         prev_num;
  logic [3:0]         match_cnt;
  logic [3:0]         match_next;

  // match_cnt == 0 means no valid previous capture to compare against.
  always_comb begin
    match_next = 4'd1;
    if ((match_cnt != 4'd0) && (digit == prev_digit) && (cap_num == prev_num)) begin
      match_next = match_cnt + 4'd1;
    end
  end

  assign publish = capture && (match_next >= STABLE_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_digit <= '0;
      prev_num   <= 8'd0;
      match_cnt  <= 4'd0;
    end else if (set_empty || set_timeout) begin
      match_cnt <= 4'd0;
    end else if (capture) begin
      prev_digit <= digit;
      prev_num   <= cap_num;
      match_cnt  <= publish ? 4'd0 : match_next;
    end
  end
`else
  assign publish = capture;
`endif

  assign set_overrun = publish && result_valid && !result_ready;

  // A publish on the same edge as an accepted handshake keeps result_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_num   <= 8'd0;
      result_valid <= 1'b0;
    end else if (publish) begin
      result       <= digit;
      result_num   <= cap_num;
      result_valid <= 1'b1;
    end else if (result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_empty   <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (set_empty) begin
        err_empty <= 1'b1;
      end else if (err_clr) begin
        err_empty <= 1'b0;
      end
      if (set_timeout) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end
      if (set_overrun) begin
        err_overrun <= 1'b1;
      end else if (err_clr) begin
        err_overrun <= 1'b0;
      end
    end
  end

endmodule
